// File: rtl/jt1943_romrq_pkg.sv
// Shared types and helpers for the N-way ROM request cache.
package jt1943_romrq_pkg;

    typedef enum logic {IDLE, WAIT} state_t;

    // Number of low address bits dropped to form the 32-bit line address
    function automatic int align_bits(input int dw);
        return (dw == 8) ? 2 : (dw == 16) ? 1 : 0;
    endfunction

    // Selected sub-word, right-justified in a 32-bit result
    function automatic logic [31:0] lane_sel(input logic [31:0] line,
                                             input logic [1:0]  sub,
                                             input int          dw);
        logic [31:0] r;
        case (dw)
            8:       r = {24'd0, line[{sub, 3'b000} +: 8]};
            16:      r = {16'd0, line[{sub[0], 4'b0000} +: 16]};
            default: r = line;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jt1943_romrq_if.sv
// Client/SDRAM side bus of the ROM request cache.
interface jt1943_romrq_if #(
    parameter int AW = 18,
    parameter int DW = 8
);
    logic [AW-1:0] addr;
    logic          addr_ok;
    logic          flush;
    logic          cen;
    logic          we;
    logic [31:0]   din;
    logic          req;
    logic [AW-1:0] addr_req;
    logic [DW-1:0] dout;
    logic          data_ok;
    logic          hit;

    modport master (output addr, addr_ok, flush, cen, we, din,
                    input  req, addr_req, dout, data_ok, hit);
    modport slave  (input  addr, addr_ok, flush, cen, we, din,
                    output req, addr_req, dout, data_ok, hit);
endinterface

// File: rtl/jt1943_romrq_way.sv
// One cache entry: valid bit, line tag and 32-bit data with match compare.
module jt1943_romrq_way #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] tag_i,
    input  logic [31:0]   data_i,
    input  logic [AW-1:0] line_i,
    output logic          match_o,
    output logic [31:0]   data_o
);
    logic          valid_q;
    logic [AW-1:0] tag_q;
    logic [31:0]   data_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (we_i) begin
            valid_q <= 1'b1;
            tag_q   <= tag_i;
            data_q  <= data_i;
        end
    end

    assign match_o = valid_q && (tag_q == line_i);
    assign data_o  = data_q;
endmodule

// File: rtl/jt1943_romrq_nway.sv
// Fully associative WAYS-entry read cache with round-robin fill and flush.
module jt1943_romrq_nway
    import jt1943_romrq_pkg::*;
#(
    parameter int AW        = 18,
    parameter int DW        = 8,
    parameter int WAYS      = 2,
    parameter int INVERT_A0 = 0
) (
    input  logic clk,
    input  logic rst_n,
    jt1943_romrq_if.slave bus
);
    localparam int            AB    = align_bits(DW);
    localparam int            VW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [AW-1:0] LMASK = ~AW'((1 << AB) - 1);

    state_t          state_q;
    logic            req_q;
    logic [AW-1:0]   addr_req_q;
    logic [VW-1:0]   victim_q;
    logic [DW-1:0]   dout_q;
    logic            data_ok_q;

    logic [AW-1:0]            line;
    logic [WAYS-1:0]          match;
    logic [WAYS-1:0][31:0]    wdata;
    logic [31:0]              hit_data;
    logic [31:0]              lane_d;
    logic                     hit;
    logic                     fill;

    assign line = bus.addr & LMASK;
    assign hit  = |match;
    assign fill = (state_q == WAIT) && bus.cen && bus.we && !bus.flush;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        jt1943_romrq_way #(.AW(AW)) u_way (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr_i   (bus.flush),
            .we_i    (fill && (victim_q == VW'(g))),
            .tag_i   (addr_req_q),
            .data_i  (bus.din),
            .line_i  (line),
            .match_o (match[g]),
            .data_o  (wdata[g])
        );
    end

    // Fills never duplicate a line, so at most one way drives the OR
    always_comb begin
        hit_data = '0;
        for (int i = 0; i < WAYS; i++)
            hit_data = hit_data | (wdata[i] & {32{match[i]}});
    end

    assign lane_d = lane_sel(hit_data, {bus.addr[1], bus.addr[0] ^ 1'(INVERT_A0)}, DW);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_req_q <= '0;
            victim_q   <= '0;
        end else if (bus.flush) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            victim_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.addr_ok && !hit) begin
                    addr_req_q <= line;
                    req_q      <= 1'b1;
                    state_q    <= WAIT;
                end
                WAIT: if (bus.cen && bus.we) begin
                    req_q    <= 1'b0;
                    victim_q <= (WAYS == 1) ? '0 : victim_q + 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_q    <= '0;
            data_ok_q <= 1'b0;
        end else if (bus.flush) begin
            data_ok_q <= 1'b0;
        end else if (bus.addr_ok && hit) begin
            dout_q    <= lane_d[DW-1:0];
            data_ok_q <= 1'b1;
        end else begin
            data_ok_q <= 1'b0;
        end
    end

    assign bus.req      = req_q;
    assign bus.addr_req = addr_req_q;
    assign bus.dout     = dout_q;
    assign bus.data_ok  = data_ok_q;
    assign bus.hit      = hit;
endmodule
